// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - stall/bubble/flush/freeze and forwarding control for the five-stage core
module hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       id_valid,
    input  logic [5:0] id_opcode,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic [4:0] id_rd_out,
    input  logic       id_reg_write,
    input  logic       id_mem_read,
    input  logic       id_mem_write,
    input  logic       id_beq_taken,
    input  logic       mem_ready,
    output logic       stall_if,
    output logic       stall_id,
    output logic       bubble_ex,
    output logic       flush_if,
    output logic       freeze,
    output logic [1:0] fwd_a,
    output logic [1:0] fwd_b,
    output logic [1:0] cause,
    output logic       mem_err
);
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQZ  = 6'h04;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    // WB needs no shadow copy: the register file writes before it reads.
    logic [4:0] ex_rd_q, ex_rd_d, mem_rd_q, mem_rd_d;
    logic       ex_wr_q, ex_wr_d, ex_ld_q, ex_ld_d, ex_acc_q, ex_acc_d;
    logic       mem_wr_q, mem_wr_d, mem_acc_q, mem_acc_d;
    logic [1:0] fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d, cause_q, cause_d;
    logic [7:0] cnt_q, cnt_d;
    logic       mem_err_q, mem_err_d;

    logic use_rs, use_rt, is_beqz, ld_haz, br_haz, frz, haz, advance_id;

    function automatic logic [1:0] fwd_sel(input logic used, input logic [4:0] src,
                                           input logic e_wr, input logic [4:0] e_rd,
                                           input logic m_wr, input logic [4:0] m_rd);
        logic [1:0] sel;
        sel = 2'b00;
        if (used && src != 5'd0) begin
            if (e_wr && e_rd == src)      sel = 2'b10;
            else if (m_wr && m_rd == src) sel = 2'b01;
        end
        return sel;
    endfunction

    always_comb begin
        is_beqz = (id_opcode == OP_BEQZ);
        use_rs  = (id_opcode == OP_RTYPE) || (id_opcode == OP_LW) ||
                  (id_opcode == OP_SW) || is_beqz;
        use_rt  = (id_opcode == OP_RTYPE) || (id_opcode == OP_SW);

        ld_haz = id_valid && ex_ld_q && (ex_rd_q != 5'd0) &&
                 ((use_rs && id_rs == ex_rd_q) || (use_rt && id_rt == ex_rd_q));
        br_haz = id_valid && is_beqz && (id_rs != 5'd0) &&
                 ((ex_wr_q && ex_rd_q == id_rs) || (mem_wr_q && mem_rd_q == id_rs));
        frz        = mem_acc_q && !mem_ready;
        haz        = !frz && (ld_haz || br_haz);
        advance_id = id_valid && !haz;

        // Combinational controls are forced low while reset is held.
        stall_if  = reset && (frz || haz);
        stall_id  = reset && (frz || haz);
        bubble_ex = reset && haz;
        freeze    = reset && frz;
        flush_if  = reset && !frz && !haz && id_valid && id_beq_taken;

        ex_rd_d   = ex_rd_q;
        ex_wr_d   = ex_wr_q;
        ex_ld_d   = ex_ld_q;
        ex_acc_d  = ex_acc_q;
        mem_rd_d  = mem_rd_q;
        mem_wr_d  = mem_wr_q;
        mem_acc_d = mem_acc_q;
        fwd_a_d   = fwd_a_q;
        fwd_b_d   = fwd_b_q;

        if (!frz) begin
            mem_rd_d  = ex_rd_q;
            mem_wr_d  = ex_wr_q;
            mem_acc_d = ex_acc_q;
            ex_rd_d   = advance_id ? id_rd_out : 5'd0;
            ex_wr_d   = advance_id && id_reg_write;
            ex_ld_d   = advance_id && id_mem_read;
            ex_acc_d  = advance_id && (id_mem_read || id_mem_write);
            fwd_a_d   = advance_id ? fwd_sel(use_rs, id_rs, ex_wr_q, ex_rd_q, mem_wr_q, mem_rd_q) : 2'b00;
            fwd_b_d   = advance_id ? fwd_sel(use_rt, id_rt, ex_wr_q, ex_rd_q, mem_wr_q, mem_rd_q) : 2'b00;
        end

        if (frz)         cause_d = 2'd3;
        else if (ld_haz) cause_d = 2'd1;
        else if (br_haz) cause_d = 2'd2;
        else             cause_d = 2'd0;

        if (!frz)                cnt_d = 8'd0;
        else if (cnt_q == 8'hff) cnt_d = cnt_q;
        else                     cnt_d = cnt_q + 8'd1;

        mem_err_d = mem_err_q || (frz && cnt_q == 8'(MEM_TIMEOUT));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_rd_q   <= 5'd0;
            ex_wr_q   <= 1'b0;
            ex_ld_q   <= 1'b0;
            ex_acc_q  <= 1'b0;
            mem_rd_q  <= 5'd0;
            mem_wr_q  <= 1'b0;
            mem_acc_q <= 1'b0;
            fwd_a_q   <= 2'b00;
            fwd_b_q   <= 2'b00;
            cause_q   <= 2'd0;
            cnt_q     <= 8'd0;
            mem_err_q <= 1'b0;
        end else begin
            ex_rd_q   <= ex_rd_d;
            ex_wr_q   <= ex_wr_d;
            ex_ld_q   <= ex_ld_d;
            ex_acc_q  <= ex_acc_d;
            mem_rd_q  <= mem_rd_d;
            mem_wr_q  <= mem_wr_d;
            mem_acc_q <= mem_acc_d;
            fwd_a_q   <= fwd_a_d;
            fwd_b_q   <= fwd_b_d;
            cause_q   <= cause_d;
            cnt_q     <= cnt_d;
            mem_err_q <= mem_err_d;
        end
    end

    assign fwd_a   = fwd_a_q;
    assign fwd_b   = fwd_b_q;
    assign cause   = cause_q;
    assign mem_err = mem_err_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - scoreboard bench for hazard_ctrl
module tb_hazard_ctrl;
    localparam logic [5:0] OP_R  = 6'h00;
    localparam logic [5:0] OP_BZ = 6'h04;
    localparam logic [5:0] OP_LW = 6'h23;
    localparam logic [5:0] OP_SW = 6'h2b;

    localparam logic [4:0] C_N  = 5'b00000;
    localparam logic [4:0] C_ST = 5'b11100;
    localparam logic [4:0] C_FL = 5'b00010;
    localparam logic [4:0] C_FZ = 5'b11001;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       id_valid = 1'b0;
    logic [5:0] id_opcode = 6'h3f;
    logic [4:0] id_rs = 5'd0, id_rt = 5'd0, id_rd_out = 5'd0;
    logic       id_reg_write = 1'b0, id_mem_read = 1'b0, id_mem_write = 1'b0, id_beq_taken = 1'b0;
    logic       mem_ready = 1'b1;
    logic       stall_if, stall_id, bubble_ex, flush_if, freeze, mem_err;
    logic [1:0] fwd_a, fwd_b, cause;

    hazard_ctrl #(.MEM_TIMEOUT(4)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd_out(id_rd_out),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .id_beq_taken(id_beq_taken),
        .mem_ready(mem_ready), .stall_if(stall_if), .stall_id(stall_id),
        .bubble_ex(bubble_ex), .flush_if(flush_if), .freeze(freeze),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .cause(cause), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [5:0] op;
        logic [4:0] rs, rt, rd;
        logic       rw, mr, mw, bt;
    } ins_t;

    typedef struct {
        string      tag;
        logic [4:0] ctl;
        logic [3:0] fwd;
        logic [1:0] cs;
        logic       err;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic ins_t mk(input logic v, input logic [5:0] op, input logic [4:0] rs,
                                input logic [4:0] rt, input logic [4:0] rd, input logic rw,
                                input logic mr, input logic mw, input logic bt);
        ins_t i;
        i.v = v; i.op = op; i.rs = rs; i.rt = rt; i.rd = rd;
        i.rw = rw; i.mr = mr; i.mw = mw; i.bt = bt;
        return i;
    endfunction

    function automatic ins_t r_op(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
        return mk(1'b1, OP_R, rs, rt, rd, 1'b1, 1'b0, 1'b0, 1'b0);
    endfunction
    function automatic ins_t lw(input logic [4:0] rt, input logic [4:0] rs);
        return mk(1'b1, OP_LW, rs, rt, rt, 1'b1, 1'b1, 1'b0, 1'b0);
    endfunction
    function automatic ins_t sw(input logic [4:0] rt, input logic [4:0] rs);
        return mk(1'b1, OP_SW, rs, rt, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    endfunction
    function automatic ins_t bz(input logic [4:0] rs, input logic taken);
        return mk(1'b1, OP_BZ, rs, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, taken);
    endfunction
    function automatic ins_t nop();
        return mk(1'b0, 6'h3f, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endfunction

    task automatic step(input string tag, input logic rst, input ins_t i, input logic rdy,
                        input logic [4:0] ctl, input logic [3:0] fw, input logic [1:0] cs,
                        input logic er);
        exp_t e;
        reset = rst;
        id_valid = i.v; id_opcode = i.op; id_rs = i.rs; id_rt = i.rt; id_rd_out = i.rd;
        id_reg_write = i.rw; id_mem_read = i.mr; id_mem_write = i.mw; id_beq_taken = i.bt;
        mem_ready = rdy;
        e.tag = tag; e.ctl = ctl; e.fwd = fw; e.cs = cs; e.err = er;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk({e.tag, ".ctl"}, 32'({stall_if, stall_id, bubble_ex, flush_if, freeze}), 32'(e.ctl));
                chk({e.tag, ".fwd"}, 32'({fwd_a, fwd_b}), 32'(e.fwd));
                chk({e.tag, ".cause"}, 32'(cause), 32'(e.cs));
                chk({e.tag, ".err"}, 32'(mem_err), 32'(e.err));
            end
        end
    end

    initial begin
        @(posedge clk);
        #1;
        step("rst",        1'b0, bz(5'd7, 1'b1), 1'b0, C_N, 4'b0000, 2'd0, 1'b0);
        // load-use
        step("lw",         1'b1, lw(5'd2, 5'd1),            1'b1, C_N,  4'b0000, 2'd0, 1'b0);
        step("ldu_stall",  1'b1, r_op(5'd3, 5'd2, 5'd4),    1'b1, C_ST, 4'b0000, 2'd0, 1'b0);
        step("ldu_held",   1'b1, r_op(5'd3, 5'd2, 5'd4),    1'b1, C_N,  4'b0000, 2'd1, 1'b0);
        step("ldu_fwd",    1'b1, r_op(5'd5, 5'd1, 5'd1),    1'b1, C_N,  4'b0100, 2'd0, 1'b0);
        // EX/MEM forwarding
        step("exfwd_pre",  1'b1, r_op(5'd6, 5'd5, 5'd5),    1'b1, C_N,  4'b0000, 2'd0, 1'b0);
        step("exfwd",      1'b1, r_op(5'd7, 5'd1, 5'd1),    1'b1, C_N,  4'b1010, 2'd0, 1'b0);
        // beqz dependent on EX, taken
        step("br_st1",     1'b1, bz(5'd7, 1'b1),            1'b1, C_ST, 4'b0000, 2'd0, 1'b0);
        step("br_st2",     1'b1, bz(5'd7, 1'b1),            1'b1, C_ST, 4'b0000, 2'd2, 1'b0);
        step("br_flush",   1'b1, bz(5'd7, 1'b1),            1'b1, C_FL, 4'b0000, 2'd2, 1'b0);
        step("squashed",   1'b1, nop(),                     1'b1, C_N,  4'b0000, 2'd0, 1'b0);
        // store freeze for 3 cycles
        step("add_r1",     1'b1, r_op(5'd1, 5'd8, 5'd8),    1'b1, C_N,  4'b0000, 2'd0, 1'b0);
        step("sw",         1'b1, sw(5'd2, 5'd1),            1'b1, C_N,  4'b0000, 2'd0, 1'b0);
        step("add_r10",    1'b1, r_op(5'd10, 5'd1, 5'd1),   1'b1, C_N,  4'b1000, 2'd0, 1'b0);
        step("frz1",       1'b1, r_op(5'd11, 5'd10, 5'd10), 1'b0, C_FZ, 4'b0101, 2'd0, 1'b0);
        step("frz2",       1'b1, r_op(5'd11, 5'd10, 5'd10), 1'b0, C_FZ, 4'b0101, 2'd3, 1'b0);
        step("frz3",       1'b1, r_op(5'd11, 5'd10, 5'd10), 1'b0, C_FZ, 4'b0101, 2'd3, 1'b0);
        step("frz_end",    1'b1, r_op(5'd11, 5'd10, 5'd10), 1'b1, C_N,  4'b0101, 2'd3, 1'b0);
        step("post_frz",   1'b1, nop(),                     1'b1, C_N,  4'b1010, 2'd0, 1'b0);
        // memory timeout with MEM_TIMEOUT = 4
        step("lw12",       1'b1, lw(5'd12, 5'd8),           1'b1, C_N,  4'b0000, 2'd0, 1'b0);
        step("lw12_ex",    1'b1, nop(),                     1'b1, C_N,  4'b0000, 2'd0, 1'b0);
        for (int k = 1; k <= 6; k++)
            step($sformatf("to%0d", k), 1'b1, nop(), 1'b0, C_FZ, 4'b0000,
                 (k == 1) ? 2'd0 : 2'd3, (k == 6));
        step("to_end",     1'b1, nop(),                     1'b1, C_N,  4'b0000, 2'd3, 1'b1);
        step("err_sticky", 1'b1, nop(),                     1'b1, C_N,  4'b0000, 2'd0, 1'b1);
        // reset during a freeze
        step("lw13",       1'b1, lw(5'd13, 5'd8),           1'b1, C_N,  4'b0000, 2'd0, 1'b1);
        step("lw13_ex",    1'b1, nop(),                     1'b1, C_N,  4'b0000, 2'd0, 1'b1);
        step("pre_rst",    1'b1, nop(),                     1'b0, C_FZ, 4'b0000, 2'd0, 1'b1);
        step("rst_mid",    1'b0, bz(5'd7, 1'b1),            1'b0, C_N,  4'b0000, 2'd0, 1'b0);
        step("add_r0",     1'b1, r_op(5'd0, 5'd1, 5'd1),    1'b1, C_N,  4'b0000, 2'd0, 1'b0);
        step("use_r0",     1'b1, r_op(5'd14, 5'd0, 5'd0),   1'b1, C_N,  4'b0000, 2'd0, 1'b0);
        step("r0_fwd",     1'b1, nop(),                     1'b1, C_N,  4'b0000, 2'd0, 1'b0);

        for (int w = 0; w < 5 && sb.size() != 0; w++)
            @(negedge clk);
        #1;
        if (sb.size() != 0)
            chk("drain", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the five-stage MIPS-subset core (R-type, lw, sw, beqz). It sits beside the decode stage, which resolves `beqz` in ID and supplies its decoded fields. It keeps a shadow copy of destination/load info for EX, MEM and WB and drives the pipeline's stall, bubble, flush and forwarding controls. It also freezes the whole pipeline while data memory withholds `mem_ready`, and flags a sticky error if that wait exceeds a limit.

## Interface
- `MEM_TIMEOUT`, 16: consecutive freeze cycles after which `mem_err` sets; range 1..255.
- `clk`  input  1  rising-edge clock.
- `reset`  input  1  asynchronous, active-low reset.
- `id_valid`  input  1  the IF/ID register holds a real instruction.
- `id_opcode`  input  6  opcode in ID.
- `id_rs`, `id_rt`  input  5 each  source fields in ID.
- `id_rd_out`  input  5  destination chosen by decode.
- `id_reg_write`, `id_mem_read`, `id_mem_write`, `id_beq_taken`  input  1 each  decode controls.
- `mem_ready`  input  1  data memory completes the MEM-stage access this cycle.
- `stall_if`  output  1  hold PC.
- `stall_id`  output  1  hold IF/ID.
- `bubble_ex`  output  1  load NOP into ID/EX.
- `flush_if`  output  1  squash the IF/ID contents at the next edge.
- `freeze`  output  1  hold ID/EX, EX/MEM and MEM/WB, and suppress WB write.
- `fwd_a`, `fwd_b`  output  2 each  EX operand select, registered: 00 = register file, 10 = EX/MEM, 01 = MEM/WB.
- `cause`  output  2  registered stall cause of the previous cycle: 0 none, 1 load-use, 2 branch, 3 memory wait.
- `mem_err`  output  1  sticky memory-timeout flag.

## Operation
- **Source use:**
  - R-type uses rs and rt.
  - lw uses rs.
  - sw uses rs and rt.
  - beqz uses rs.
  - Any other opcode uses nothing.
  - Register 0 never matches.
- **Shadow stages.** `ex_{rd,wr,ld}`, `mem_{rd,wr,acc}` and `wb_{rd,wr}`, where `acc` = lw or sw.
- **freeze** = `mem_acc & !mem_ready`.
- **ld_haz** = `id_valid & ex_ld & ex_rd≠0 & ex_rd` matches a used source.
- **br_haz** = `id_valid`, opcode beqz, rs≠0, and either:
  - `ex_wr & ex_rd==rs`, or
  - `mem_wr & mem_rd==rs`.
  - WB is not a hazard: the register file writes before it reads.
- **Priority: freeze > (ld_haz | br_haz) > branch flush.**
  - freeze: `stall_if = stall_id = freeze = 1`; `bubble_ex = 0`; `flush_if = 0`.
  - ld_haz or br_haz: `stall_if = stall_id = bubble_ex = 1`; `flush_if = 0`.
  - Otherwise: `flush_if = id_valid & id_beq_taken`.
- **Shadow advance on each edge without freeze:**
  - `wb ← mem`.
  - `mem ← ex`.
  - `ex ← id` fields when `id_valid` and no bubble; otherwise `ex ← empty` (wr=0, ld=0, rd=0).
- **Shadow update on freeze:** all shadow registers hold.
- **Forwarding, registered, computed on the same advance for the instruction entering EX.**
  - For each used source: `10` if `ex_wr & ex_rd==src`, else `01` if `mem_wr & mem_rd==src`, else `00`.
  - An unused source or a bubble gives `00`.
  - On freeze both selects hold.
- **Wait counter (8 bits).**
  - Increments on each freeze cycle and saturates at 255.
  - Clears on any non-freeze cycle.
  - When the counter equals `MEM_TIMEOUT` during freeze, `mem_err` sets and stays set until reset.
- **cause** registers the priority-encoded stall reason each cycle.

## Timing
- Stall, bubble, flush and freeze are combinational: they act at the edge ending the cycle in which the condition is present.
- `fwd_*` and `cause` are valid one cycle after the deciding edge.
- Load-use costs exactly 1 stall cycle.
- Branch hazards:
  - beqz dependent on the instruction in EX costs 2 stall cycles.
  - beqz dependent on the instruction in MEM costs 1 stall cycle.
- A taken branch costs 1 squashed slot.
- Reset, asynchronous and active-low, which can land mid-operation. It must:
  - clear all shadow registers, `fwd_*`, `cause`, the counter and `mem_err`;
  - force all outputs to 0 while asserted.
- First edge after reset release behaves as RUN with an empty pipeline.
- A beqz that is taken and stalled asserts `flush_if` only in the cycle its stall drops.
- freeze coinciding with ld_haz: the load-use stall still occurs after the freeze ends, because the shadow state is held.

## Test plan
- `lw r2,0(r1)` then `add r3,r2,r4` → one cycle of `stall_if = bubble_ex = 1`, `cause = 1` next cycle; the add then enters EX with `fwd_a = 01`.
- `add r5,r1,r1` then `sub r6,r5,r5` → no stall; `fwd_a = fwd_b = 10`.
- `add r7,…` then `beqz r7` (taken) → 2 stall cycles, then `flush_if = 1` for 1 cycle.
- sw in MEM with `mem_ready = 0` for 3 cycles → `freeze = 1` for exactly 3 cycles; shadow registers and `fwd_*` unchanged; `cause = 3`.
- `MEM_TIMEOUT = 4` with `mem_ready` held low for 6 cycles → `mem_err` rises after the 5th freeze cycle and stays 1 after `mem_ready`.
- `reset` pulsed low during a freeze → all outputs 0 immediately; after release, `add r0,…` followed by a use of r0 gives no stall and `fwd = 00`.
